// File: rtl/y86_regfile_mp.sv
// y86_regfile_mp: Y86 register file with two write ports (valE, valM), two
// combinational read ports and a per-register busy scoreboard for decode stalls.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the reads.
module y86_regfile_mp #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ADDR_W    = 4,
   parameter int unsigned       REG_CNT   = 16,
   parameter int unsigned       NONE_ADDR = 15,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en_e,
   input  logic [ADDR_W-1:0] wr_addr_e,
   input  logic [DATA_W-1:0] wr_data_e,
   input  logic              wr_en_m,
   input  logic [ADDR_W-1:0] wr_addr_m,
   input  logic [DATA_W-1:0] wr_data_m,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   output logic              rd_busy_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_busy_b,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned IDX_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

   logic [DATA_W-1:0]  regs [REG_CNT];
   logic [REG_CNT-1:0] busy;
   logic [REG_CNT-1:0] busy_nxt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               we_e_ok;
   logic               we_m_ok;
   logic               rsv_ok;

   // A real register: not the none slot and inside the populated range
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (a != ADDR_W'(NONE_ADDR)) && ({1'b0, a} < CNT_W'(REG_CNT));
   endfunction

   function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
      return IDX_W'(a);
   endfunction

   assign we_e_ok = wr_en_e && addr_ok(wr_addr_e);
   assign we_m_ok = wr_en_m && addr_ok(wr_addr_m);
   assign rsv_ok  = rsv_en  && addr_ok(rsv_addr);

   // Next busy vector: writes retire producers, a same-cycle reserve re-arms
   always_comb begin
      busy_nxt = busy;
      if (we_e_ok) busy_nxt[idx(wr_addr_e)] = 1'b0;
      if (we_m_ok) busy_nxt[idx(wr_addr_m)] = 1'b0;
      if (rsv_ok)  busy_nxt[idx(rsv_addr)]  = 1'b1;
   end

   // Population count of the next busy vector
   always_comb begin
      cnt_nxt = '0;
      for (int unsigned i = 0; i < REG_CNT; i++) begin
         cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
      end
   end

   // State update; port M is written last so it wins on a shared address
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < REG_CNT; i++) begin
            regs[i] <= RESET_VAL;
         end
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         if (we_e_ok) regs[idx(wr_addr_e)] <= wr_data_e;
         if (we_m_ok) regs[idx(wr_addr_m)] <= wr_data_m;
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

   // Read port A: stored state, optionally overridden by same-cycle writes
   always_comb begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
      if (addr_ok(rd_addr_a)) begin
         rd_data_a = regs[idx(rd_addr_a)];
         rd_busy_a = busy[idx(rd_addr_a)];
`ifdef REGFILE_BYPASS_EN
         if (we_m_ok && (wr_addr_m == rd_addr_a)) begin
            rd_data_a = wr_data_m;
            rd_busy_a = rsv_ok && (rsv_addr == rd_addr_a);
         end else if (we_e_ok && (wr_addr_e == rd_addr_a)) begin
            rd_data_a = wr_data_e;
            rd_busy_a = rsv_ok && (rsv_addr == rd_addr_a);
         end
`endif
      end
   end

   // Read port B: identical to port A
   always_comb begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
      if (addr_ok(rd_addr_b)) begin
         rd_data_b = regs[idx(rd_addr_b)];
         rd_busy_b = busy[idx(rd_addr_b)];
`ifdef REGFILE_BYPASS_EN
         if (we_m_ok && (wr_addr_m == rd_addr_b)) begin
            rd_data_b = wr_data_m;
            rd_busy_b = rsv_ok && (rsv_addr == rd_addr_b);
         end else if (we_e_ok && (wr_addr_e == rd_addr_b)) begin
            rd_data_b = wr_data_e;
            rd_busy_b = rsv_ok && (rsv_addr == rd_addr_b);
         end
`endif
      end
   end

endmodule

// File: tb/tb_y86_regfile_mp.sv
// Testbench for y86_regfile_mp: reset sweep, directed table, multi-cycle
// sequences, then randomized traffic checked against a behavioural model.
module tb_y86_regfile_mp;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_en_e;
   logic [3:0]  wr_addr_e;
   logic [31:0] wr_data_e;
   logic        wr_en_m;
   logic [3:0]  wr_addr_m;
   logic [31:0] wr_data_m;
   logic [3:0]  rd_addr_a;
   logic [31:0] rd_data_a;
   logic        rd_busy_a;
   logic [3:0]  rd_addr_b;
   logic [31:0] rd_data_b;
   logic        rd_busy_b;
   logic        rsv_en;
   logic [3:0]  rsv_addr;
   logic [4:0]  busy_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_regs [16];
   bit          m_busy [16];

   typedef struct {
      logic        we_e;  logic [3:0] wa_e; logic [31:0] wd_e;
      logic        we_m;  logic [3:0] wa_m; logic [31:0] wd_m;
      logic        rsv;   logic [3:0] rsa;
      logic [3:0]  ra;    logic [3:0] rb;
      logic [31:0] xa;    logic       xba;
      logic [31:0] xb;    logic       xbb;
      logic [4:0]  xcnt;
   } vec_t;

   vec_t tbl [13];

   y86_regfile_mp dut (
      .clock     (clock),
      .reset     (reset),
      .wr_en_e   (wr_en_e),
      .wr_addr_e (wr_addr_e),
      .wr_data_e (wr_data_e),
      .wr_en_m   (wr_en_m),
      .wr_addr_m (wr_addr_m),
      .wr_data_m (wr_data_m),
      .rd_addr_a (rd_addr_a),
      .rd_data_a (rd_data_a),
      .rd_busy_a (rd_busy_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_b (rd_data_b),
      .rd_busy_b (rd_busy_b),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .busy_cnt  (busy_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit real_reg(input logic [3:0] a);
      return a != 4'hF;
   endfunction

   // Expected read result from the model, including same-cycle forwarding
   task automatic exp_read(input logic [3:0] a, output logic [31:0] d, output logic b);
      d = 32'h0;
      b = 1'b0;
      if (real_reg(a)) begin
         d = m_regs[a];
         b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
         if (wr_en_m && wr_addr_m == a) begin
            d = wr_data_m;
            b = rsv_en && rsv_addr == a;
         end else if (wr_en_e && wr_addr_e == a) begin
            d = wr_data_e;
            b = rsv_en && rsv_addr == a;
         end
`endif
      end
   endtask

   function automatic logic [31:0] m_count();
      int c = 0;
      foreach (m_busy[i]) c += int'(m_busy[i]);
      return 32'(c);
   endfunction

   // Advance the model by one clock edge using the inputs held at that edge
   task automatic model_update();
      if (reset) begin
         foreach (m_regs[i]) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (wr_en_e && real_reg(wr_addr_e)) begin
            m_regs[wr_addr_e] = wr_data_e;
            m_busy[wr_addr_e] = 1'b0;
         end
         if (wr_en_m && real_reg(wr_addr_m)) begin
            m_regs[wr_addr_m] = wr_data_m;
            m_busy[wr_addr_m] = 1'b0;
         end
         if (rsv_en && real_reg(rsv_addr)) m_busy[rsv_addr] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      model_update();
   endtask

   task automatic idle();
      reset = 1'b0;
      wr_en_e = 1'b0; wr_addr_e = 4'h0; wr_data_e = 32'h0;
      wr_en_m = 1'b0; wr_addr_m = 4'h0; wr_data_m = 32'h0;
      rsv_en = 1'b0;  rsv_addr = 4'h0;
   endtask

   task automatic model_check(input string tag);
      logic [31:0] d;
      logic        b;
      exp_read(rd_addr_a, d, b);
      chk({tag, "_data_a"}, rd_data_a, d);
      chk({tag, "_busy_a"}, 32'(rd_busy_a), 32'(b));
      exp_read(rd_addr_b, d, b);
      chk({tag, "_data_b"}, rd_data_b, d);
      chk({tag, "_busy_b"}, 32'(rd_busy_b), 32'(b));
      chk({tag, "_busy_cnt"}, 32'(busy_cnt), m_count());
   endtask

   initial begin
      // Directed rows; expectations are what the reads show before the row's edge
      tbl[0]  = '{1, 4'd3, 32'h11111111, 1, 4'd3, 32'h22222222, 0, 4'd0, 4'd0, 4'd1,
                  32'h0, 0, 32'h0, 0, 5'd0};
      tbl[1]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd0, 4'd3, 4'd3,
                  32'h22222222, 0, 32'h22222222, 0, 5'd0};
      tbl[2]  = '{1, 4'd15, 32'hDEADBEEF, 0, 4'd0, 32'h0, 0, 4'd0, 4'd15, 4'd3,
                  32'h0, 0, 32'h22222222, 0, 5'd0};
      tbl[3]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd2, 4'd15, 4'd3,
                  32'h0, 0, 32'h22222222, 0, 5'd0};
      tbl[4]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd5, 4'd2, 4'd5,
                  32'h0, 1, 32'h0, 0, 5'd1};
      tbl[5]  = '{1, 4'd2, 32'hAAAA0002, 0, 4'd0, 32'h0, 0, 4'd0, 4'd5, 4'd3,
                  32'h0, 1, 32'h22222222, 0, 5'd2};
      tbl[6]  = '{0, 4'd0, 32'h0, 1, 4'd5, 32'h00000055, 1, 4'd5, 4'd2, 4'd3,
                  32'hAAAA0002, 0, 32'h22222222, 0, 5'd1};
      tbl[7]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd0, 4'd5, 4'd2,
                  32'h00000055, 1, 32'hAAAA0002, 0, 5'd1};
      tbl[8]  = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 4'd5, 4'd5, 4'd15,
                  32'h00000055, 1, 32'h0, 0, 5'd1};
      tbl[9]  = '{1, 4'd7, 32'h00000077, 1, 4'd5, 32'h00000066, 0, 4'd0, 4'd2, 4'd3,
                  32'hAAAA0002, 0, 32'h22222222, 0, 5'd1};
      tbl[10] = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd0, 4'd5, 4'd7,
                  32'h00000066, 0, 32'h00000077, 0, 5'd0};
      tbl[11] = '{0, 4'd0, 32'h0, 1, 4'd15, 32'h12345678, 1, 4'd15, 4'd15, 4'd5,
                  32'h0, 0, 32'h00000066, 0, 5'd0};
      tbl[12] = '{0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd0, 4'd15, 4'd3,
                  32'h0, 0, 32'h22222222, 0, 5'd0};

      idle();
      rd_addr_a = 4'h0;
      rd_addr_b = 4'h0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Every address reads as zero and idle after reset
      for (int i = 0; i < 16; i++) begin
         rd_addr_a = 4'(i);
         rd_addr_b = 4'(15 - i);
         @(negedge clock);
         chk("rst_data_a", rd_data_a, 32'h0);
         chk("rst_busy_a", 32'(rd_busy_a), 32'h0);
         chk("rst_data_b", rd_data_b, 32'h0);
         chk("rst_busy_b", 32'(rd_busy_b), 32'h0);
         chk("rst_busy_cnt", 32'(busy_cnt), 32'h0);
         tick();
      end

      // Directed table
      for (int i = 0; i < 13; i++) begin
         wr_en_e = tbl[i].we_e; wr_addr_e = tbl[i].wa_e; wr_data_e = tbl[i].wd_e;
         wr_en_m = tbl[i].we_m; wr_addr_m = tbl[i].wa_m; wr_data_m = tbl[i].wd_m;
         rsv_en  = tbl[i].rsv;  rsv_addr  = tbl[i].rsa;
         rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
         @(negedge clock);
         chk($sformatf("tbl%0d_data_a", i), rd_data_a, tbl[i].xa);
         chk($sformatf("tbl%0d_busy_a", i), 32'(rd_busy_a), 32'(tbl[i].xba));
         chk($sformatf("tbl%0d_data_b", i), rd_data_b, tbl[i].xb);
         chk($sformatf("tbl%0d_busy_b", i), 32'(rd_busy_b), 32'(tbl[i].xbb));
         chk($sformatf("tbl%0d_busy_cnt", i), 32'(busy_cnt), 32'(tbl[i].xcnt));
         tick();
      end
      idle();

      // Read r4 in the same cycle it is written
      wr_en_e = 1'b1; wr_addr_e = 4'd4; wr_data_e = 32'h0000ABCD;
      rd_addr_a = 4'd4; rd_addr_b = 4'd4;
      @(negedge clock);
`ifdef REGFILE_BYPASS_EN
      chk("same_cycle_r4_a", rd_data_a, 32'h0000ABCD);
      chk("same_cycle_r4_b", rd_data_b, 32'h0000ABCD);
`else
      chk("same_cycle_r4_a", rd_data_a, 32'h0);
      chk("same_cycle_r4_b", rd_data_b, 32'h0);
`endif
      tick();
      idle();
      @(negedge clock);
      chk("next_cycle_r4_a", rd_data_a, 32'h0000ABCD);
      chk("next_cycle_r4_b", rd_data_b, 32'h0000ABCD);
      tick();

      // Reset in flight discards data, reservations and a concurrent write
      wr_en_e = 1'b1; wr_addr_e = 4'd1; wr_data_e = 32'h5;
      rsv_en = 1'b1; rsv_addr = 4'd6;
      tick();
      idle();
      rd_addr_a = 4'd1; rd_addr_b = 4'd6;
      @(negedge clock);
      chk("pre_rst_r1", rd_data_a, 32'h5);
      chk("pre_rst_busy_r6", 32'(rd_busy_b), 32'h1);
      chk("pre_rst_busy_cnt", 32'(busy_cnt), 32'h1);
      reset = 1'b1;
      wr_en_e = 1'b1; wr_addr_e = 4'd1; wr_data_e = 32'h7;
      rsv_en = 1'b1; rsv_addr = 4'd3;
      tick();
      idle();
      @(negedge clock);
      chk("post_rst_r1", rd_data_a, 32'h0);
      chk("post_rst_busy_r6", 32'(rd_busy_b), 32'h0);
      chk("post_rst_busy_cnt", 32'(busy_cnt), 32'h0);
      rd_addr_a = 4'd3; rd_addr_b = 4'd4;
      #1;
      chk("post_rst_busy_r3", 32'(rd_busy_a), 32'h0);
      chk("post_rst_r4", rd_data_b, 32'h0);
      tick();

      // Randomized traffic against the behavioural model
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 63) == 0);
         wr_en_e   = 1'($urandom_range(0, 1));
         wr_addr_e = 4'($urandom_range(0, 15));
         wr_data_e = $urandom;
         wr_en_m   = 1'($urandom_range(0, 1));
         wr_addr_m = ($urandom_range(0, 3) == 0) ? wr_addr_e : 4'($urandom_range(0, 15));
         wr_data_m = $urandom;
         rsv_en    = ($urandom_range(0, 2) != 0);
         rsv_addr  = ($urandom_range(0, 3) == 0) ? wr_addr_m : 4'($urandom_range(0, 15));
         rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr_m : 4'($urandom_range(0, 15));
         rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr_e : 4'($urandom_range(0, 15));
         @(negedge clock);
         model_check("rnd");
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
